hdlc_bus_sequencer: RTL

Bus master that sequences the HDLC controller's 3-bit register interface on behalf of the rest of the system. It polls RX status, drains received frames byte-by-byte into a downstream valid/ready stream, and loads transmit frames from an upstream valid/ready stream into the TX buffer before starting transmission. It shares the single register port between the RX and TX paths with round-robin arbitration and sits directly between the user datapath and the HDLC address interface.

---
 rtl/hdlc_bus_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/hdlc_bus_sequencer.sv
// Register-port bus master for the HDLC controller: polls and drains RX frames into a
// downstream stream and loads upstream TX frames into the TX buffer, arbitrating round-robin.
module hdlc_bus_sequencer #(
  parameter int MAX_FRAME = 126,
  parameter int HOLDOFF   = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  output logic [2:0] Address,
  output logic       WriteEnable,
  output logic       ReadEnable,
  output logic [7:0] DataIn,
  input  logic [7:0] DataOut,
  input  logic       FcsEnable,
  input  logic       TxValid,
  input  logic [7:0] TxData,
  input  logic       TxLast,
  output logic       TxReady,
  output logic       TxErr,
  output logic       RxValid,
  output logic [7:0] RxData,
  output logic       RxLast,
  input  logic       RxReady,
  output logic       RxErr
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_POLL_RX  = 4'd1;
  localparam logic [3:0] S_RX_LEN   = 4'd2;
  localparam logic [3:0] S_RX_DATA  = 4'd3;
  localparam logic [3:0] S_RX_DROP  = 4'd4;
  localparam logic [3:0] S_TX_STAT  = 4'd5;
  localparam logic [3:0] S_TX_WRITE = 4'd6;
  localparam logic [3:0] S_TX_START = 4'd7;
  localparam logic [3:0] S_TX_ABORT = 4'd8;
  localparam logic [3:0] S_TX_FLUSH = 4'd9;
  localparam logic [3:0] S_WAIT     = 4'd10;

  localparam logic       GRANT_RX  = 1'b0;
  localparam logic       GRANT_TX  = 1'b1;
  localparam logic [7:0] MAX_C     = 8'(MAX_FRAME);
  localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF - 1);

  logic [3:0] state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] hold_q, hold_d;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    hold_d       = 8'd0;
    Address      = 3'd0;
    WriteEnable  = 1'b0;
    ReadEnable   = 1'b0;
    DataIn       = 8'd0;
    TxReady      = 1'b0;
    TxErr        = 1'b0;
    RxValid      = 1'b0;
    RxData       = 8'd0;
    RxLast       = 1'b0;
    RxErr        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (TxValid && (last_grant_q == GRANT_RX)) begin
          state_d      = S_TX_STAT;
          last_grant_d = GRANT_TX;
        end else begin
          state_d      = S_POLL_RX;
          last_grant_d = GRANT_RX;
        end
      end
      S_POLL_RX: begin
        ReadEnable = 1'b1;
        Address    = 3'd2;
        if (!DataOut[0])          state_d = S_IDLE;
        else if (|DataOut[4:2])   state_d = S_RX_DROP;
        else                      state_d = S_RX_LEN;
      end
      S_RX_LEN: begin
        ReadEnable = 1'b1;
        Address    = 3'd4;
        if ((DataOut == 8'd0) || (DataOut > MAX_C)) begin
          state_d = S_RX_DROP;
        end else begin
          cnt_d   = DataOut;
          state_d = S_RX_DATA;
        end
      end
      S_RX_DATA: begin
        // The buffer address is only driven while a pop is strobed, keeping the idle bus at zero.
        RxValid    = 1'b1;
        RxData     = DataOut;
        RxLast     = (cnt_q == 8'd1);
        ReadEnable = RxReady;
        if (RxReady) begin
          Address = 3'd3;
          cnt_d   = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = S_WAIT;
        end
      end
      S_RX_DROP: begin
        WriteEnable = 1'b1;
        Address     = 3'd2;
        DataIn      = {2'b00, FcsEnable, 3'b000, 1'b1, 1'b0};
        RxErr       = 1'b1;
        state_d     = S_WAIT;
      end
      S_TX_STAT: begin
        ReadEnable = 1'b1;
        Address    = 3'd0;
        if (DataOut[0] && !DataOut[4]) begin
          cnt_d   = 8'd0;
          state_d = S_TX_WRITE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TX_WRITE: begin
        TxReady = (cnt_q < MAX_C);
        if (TxValid && (cnt_q < MAX_C)) begin
          WriteEnable = 1'b1;
          Address     = 3'd1;
          DataIn      = TxData;
          cnt_d       = cnt_q + 8'd1;
          if (TxLast) state_d = S_TX_START;
        end else if (cnt_q == MAX_C) begin
          state_d = S_TX_ABORT;
        end
      end
      S_TX_START: begin
        WriteEnable = 1'b1;
        Address     = 3'd0;
        DataIn      = 8'h02;
        state_d     = S_WAIT;
      end
      S_TX_ABORT: begin
        WriteEnable = 1'b1;
        Address     = 3'd0;
        DataIn      = 8'h04;
        TxErr       = 1'b1;
        state_d     = S_TX_FLUSH;
      end
      S_TX_FLUSH: begin
        // Remainder of an oversize frame is swallowed without touching the bus.
        TxReady = 1'b1;
        if (TxValid && TxLast) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (hold_q == HOLD_LAST) state_d = S_IDLE;
        else                     hold_d  = hold_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= GRANT_RX;
      cnt_q        <= 8'd0;
      hold_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
    end
  end

endmodule
